dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: IDLE/BUSY/DONE handshake, store lane steering and load extension.
// Define DMEM_TIMEOUT_EN to abort a BUSY wait after TIMEOUT_CYCLES with a bus_err pulse.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  func3,
    output logic [31:0] memOut,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 30;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      lane_q, lane_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [2:0]      func3_q, func3_d;
    logic            we_q, we_d;
    logic [DW-1:0]   memout_q, memout_d;
    logic            misalign_q, misalign_d;
    logic            buserr_q, buserr_d;

    logic            req;
    size_t           size;
    logic            mis;
    logic [3:0]      be_new;
    logic [DW-1:0]   wdata_new;
    logic            timeout;

    // Lane select and sign/zero extension of the returned word.
    function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] rd, input logic [1:0] lane,
                                               input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lane, 3'b000} +: 8];
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    // Request decode: access size, alignment and store lane steering.
    always_comb begin
        req = memRead | memWrite;
        case (func3)
            3'b000, 3'b100: size = SZ_BYTE;
            3'b001, 3'b101: size = SZ_HALF;
            default:        size = SZ_WORD;
        endcase
        mis = ((size == SZ_HALF) && address[0]) ||
              ((size == SZ_WORD) && (address[1:0] != 2'b00));
        case (size)
            SZ_BYTE: begin
                be_new    = 4'b0001 << address[1:0];
                wdata_new = {4{writeData[7:0]}};
            end
            SZ_HALF: begin
                be_new    = 4'b0011 << {address[1], 1'b0};
                wdata_new = {2{writeData[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = writeData;
            end
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts BUSY cycles without ack; zero whenever not waiting.
    always_comb begin
        cnt_d   = '0;
        timeout = 1'b0;
        if (state_q == BUSY && !mem_ack) begin
            cnt_d   = cnt_q + CNT_W'(1);
            timeout = (cnt_d == CNT_W'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Next-state and latch logic; misalign/bus_err default low so they pulse only in DONE.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        func3_d    = func3_q;
        we_d       = we_q;
        memout_d   = memout_q;
        misalign_d = 1'b0;
        buserr_d   = 1'b0;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    addr_d  = address[31:2];
                    lane_d  = address[1:0];
                    wdata_d = wdata_new;
                    be_d    = memWrite ? be_new : 4'b1111;
                    func3_d = func3;
                    we_d    = memWrite;
                    if (mis) begin
                        state_d    = DONE;
                        misalign_d = 1'b1;
                        memout_d   = '0;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack) begin
                    state_d  = DONE;
                    memout_d = we_q ? '0 : load_ext(mem_rdata, lane_q, func3_q);
                end else if (timeout) begin
                    state_d  = DONE;
                    buserr_d = 1'b1;
                    memout_d = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            func3_q    <= '0;
            we_q       <= 1'b0;
            memout_q   <= '0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            func3_q    <= func3_d;
            we_q       <= we_d;
            memout_q   <= memout_d;
            misalign_q <= misalign_d;
            buserr_q   <= buserr_d;
        end
    end

    // mem_req follows the state flop so an async reset drops it immediately.
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign memOut    = memout_q;
    assign misalign  = misalign_q;
    assign bus_err   = buserr_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: scoreboard of expected DONE results plus per-cycle bus checks.
module tb_dmem_ctrl;

    localparam int unsigned TO = 16;

    typedef struct {
        logic [31:0] mo;
        logic        mis;
        logic        berr;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address, writeData;
    logic        memRead, memWrite;
    logic [2:0]  func3;
    logic [31:0] memOut;
    logic        stall, misalign, bus_err, mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] tb_mem [logic [29:0]];
    exp_t        sb [$];
    logic [31:0] last_mo;

    dmem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .address(address), .writeData(writeData),
        .memRead(memRead), .memWrite(memWrite), .func3(func3), .memOut(memOut),
        .stall(stall), .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic m_mis(input logic [31:0] a, input logic [2:0] f3);
        int s;
        s = m_size(f3);
        return (s == 2 && a[0]) || (s == 4 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] f3);
        logic [31:0] sh;
        sh = w >> (int'(a[1:0]) * 8);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f3, input logic wr);
        logic [3:0] be;
        int s, off;
        s   = m_size(f3);
        off = int'(a[1:0]);
        be  = 4'h0;
        if (!wr) return 4'hF;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + s) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [31:0] d, input logic [2:0] f3);
        case (m_size(f3))
            1:       return {4{d[7:0]}};
            2:       return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] rd_mem(input logic [29:0] idx);
        return tb_mem.exists(idx) ? tb_mem[idx] : 32'h0;
    endfunction

    // Issue one access at the current IDLE point, act as the memory, check DONE and the IDLE after.
    task automatic do_access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input int ack_dly);
        exp_t        e, got;
        int          cyc, busy;
        bit          done;
        logic [31:0] word;
        logic [3:0]  be_w;
        e.mis  = m_mis(a, f3);
        e.berr = !e.mis && (ack_dly < 0);
        e.mo   = (e.mis || wr || e.berr) ? 32'h0 : m_load(rd_mem(a[31:2]), a, f3);
        e.lat  = e.mis ? 1 : (e.berr ? int'(TO) + 1 : ack_dly + 2);
        sb.push_back(e);
        address = a; writeData = wd; func3 = f3; memRead = rd; memWrite = wr;
        #1;
        chk({tag, "_stall_c0"}, 32'(stall), 32'h1);
        chk({tag, "_req_c0"}, 32'(mem_req), 32'h0);
        cyc = 0; busy = 0; done = 1'b0;
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_0000 ^ 32'(cyc);
            if (stall === 1'b0) begin
                done = 1'b1;
                got  = sb.pop_front();
                memRead = 1'b0; memWrite = 1'b0;
                chk({tag, "_latency"}, 32'(cyc), 32'(got.lat));
                chk({tag, "_memOut"}, memOut, got.mo);
                chk({tag, "_misalign"}, 32'(misalign), 32'(got.mis));
                chk({tag, "_bus_err"}, 32'(bus_err), 32'(got.berr));
                chk({tag, "_req_done"}, 32'(mem_req), 32'h0);
            end else begin
                chk({tag, "_req_busy"}, 32'(mem_req), 32'h1);
                chk({tag, "_addr"}, 32'(mem_addr), {2'b00, a[31:2]});
                chk({tag, "_be"}, 32'(mem_be), 32'(m_be(a, f3, wr)));
                chk({tag, "_we"}, 32'(mem_we), 32'(wr));
                if (wr) chk({tag, "_wdata"}, mem_wdata, m_wd(wd, f3));
                if (busy == ack_dly) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        word = rd_mem(mem_addr);
                        be_w = mem_be;
                        for (int i = 0; i < 4; i++)
                            if (be_w[i]) word[8*i +: 8] = mem_wdata[8*i +: 8];
                        tb_mem[mem_addr] = word;
                    end else begin
                        mem_rdata = rd_mem(mem_addr);
                    end
                end
                busy++;
            end
        end
        if (!done) begin
            chk({tag, "_no_done"}, 32'(done), 32'h1);
            memRead = 1'b0; memWrite = 1'b0; mem_ack = 1'b0;
            sb.delete();
            reset = 1'b0; #2 reset = 1'b1;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            chk({tag, "_hold_memOut"}, memOut, got.mo);
            chk({tag, "_idle_misalign"}, 32'(misalign), 32'h0);
            chk({tag, "_idle_bus_err"}, 32'(bus_err), 32'h0);
            chk({tag, "_idle_stall"}, 32'(stall), 32'h0);
            last_mo = got.mo;
        end
    endtask

    initial begin
        reset = 1'b0; address = '0; writeData = '0; memRead = 1'b0; memWrite = 1'b0;
        func3 = '0; mem_rdata = '0; mem_ack = 1'b0; last_mo = '0;
        tb_mem[30'h40] = 32'h80FF_1234;
        #3;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_memOut", memOut, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        do_access("lb_103", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0);
        chk("lb_103_const", memOut, 32'hFFFF_FF80);
        do_access("sh_102", 1'b0, 1'b1, 3'b001, 32'h102, 32'hDEAD_BEEF, 0);
        chk("sh_102_be", 32'(mem_be), 32'hC);
        chk("sh_102_wdata", mem_wdata, 32'hBEEF_BEEF);
        chk("sh_102_addr", 32'(mem_addr), 32'h40);
        do_access("lw_101_mis", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0);
        do_access("lh_102", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 2);
        chk("lh_102_const", memOut, 32'hFFFF_BEEF);
        do_access("lhu_100", 1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 1);
        do_access("lbu_101", 1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 0);
        do_access("lh_103_mis", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 0);
        do_access("sb_201", 1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00A5, 3);
        do_access("lb_201", 1'b1, 1'b0, 3'b000, 32'h201, 32'h0, 0);
        chk("lb_201_const", memOut, 32'hFFFF_FFA5);

        do_access("sw_20", 1'b0, 1'b1, 3'b010, 32'h20, 32'h1122_3344, 0);
        do_access("lw_20_b2b", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 0);
        chk("lw_20_const", memOut, 32'h1122_3344);
        do_access("f3_011_ld", 1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 1);
        do_access("f3_110_mis", 1'b1, 1'b0, 3'b110, 32'h22, 32'h0, 0);
        do_access("f3_111_st", 1'b0, 1'b1, 3'b111, 32'h24, 32'h5566_7788, 0);
        do_access("rdwr_30", 1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 1);
        do_access("lw_30", 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 0);
        chk("lw_30_const", memOut, 32'hCAFE_F00D);

        // Stray ack in IDLE must not start anything or disturb memOut.
        mem_ack = 1'b1;
        @(posedge clk); #1;
        chk("stray_ack_req", 32'(mem_req), 32'h0);
        chk("stray_ack_stall", 32'(stall), 32'h0);
        chk("stray_ack_memOut", memOut, last_mo);
        mem_ack = 1'b0;

        for (int k = 0; k < 8; k++) begin
            logic [31:0] ra;
            logic [2:0]  rf;
            int          pick;
            ra   = 32'h300 + 32'($urandom_range(0, 63));
            pick = int'($urandom_range(0, 4));
            rf   = (pick == 0) ? 3'b000 : (pick == 1) ? 3'b001 : (pick == 2) ? 3'b010 :
                   (pick == 3) ? 3'b100 : 3'b101;
            tb_mem[ra[31:2]] = $urandom();
            do_access("rnd_ld", 1'b1, 1'b0, rf, ra, 32'h0, int'($urandom_range(0, 3)));
        end

`ifdef DMEM_TIMEOUT_EN
        do_access("timeout", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, -1);
        do_access("ack_wins", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, int'(TO) - 1);
`else
        do_access("long_wait", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 100);
`endif

        // Async reset in the second BUSY cycle, then a fresh access.
        address = 32'h10; func3 = 3'b010; memRead = 1'b1; memWrite = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_busy_req", 32'(mem_req), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_req", 32'(mem_req), 32'h0);
        chk("rst_async_be", 32'(mem_be), 32'h0);
        chk("rst_async_memOut", memOut, 32'h0);
        memRead = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_stall", 32'(stall), 32'h0);
        tb_mem[30'h0] = 32'h0000_00AB;
        do_access("lbu_0", 1'b1, 1'b0, 3'b100, 32'h0, 32'h0, 0);
        chk("lbu_0_const", memOut, 32'h0000_00AB);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

endmodule
